// File: rtl/icache_assoc_param_pkg.sv
// icache_assoc_param_pkg: FSM encoding and geometry helpers shared by the instruction cache
package icache_assoc_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_LOOKUP,
        S_MEM_REQ,
        S_RECV,
        S_REFILL,
        S_RESP
    } state_t;

    function automatic int offset_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int plru_bits(input int num_ways);
        return num_ways - 1;
    endfunction

endpackage

// File: rtl/icache_assoc_param_plru.sv
// icache_assoc_param_plru: per-set tree pseudo-LRU, victim walk and update on access
module icache_assoc_param_plru
    import icache_assoc_param_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 4,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [SET_W-1:0] i_rd_set,
    output logic [WAY_W-1:0] o_victim,
    input  logic             i_upd_en,
    input  logic [SET_W-1:0] i_upd_set,
    input  logic [WAY_W-1:0] i_upd_way
);

    localparam int TREE_W = plru_bits(NUM_WAYS);

    logic [TREE_W-1:0] r_tree [NUM_SETS];
    logic [TREE_W-1:0] w_upd;
    logic [WAY_W-1:0]  w_vnode;
    logic [WAY_W-1:0]  w_unode;
    logic              w_vbit;

    // walk from the root (heap node 1); a 0 bit steers toward the lower-numbered half
    always_comb begin
        w_vnode  = WAY_W'(1);
        w_vbit   = 1'b0;
        o_victim = '0;
        for (int l = 0; l < WAY_W; l++) begin
            w_vbit   = r_tree[i_rd_set][w_vnode - 1'b1];
            o_victim = (o_victim << 1) | WAY_W'(w_vbit);
            w_vnode  = (w_vnode << 1) | WAY_W'(w_vbit);
        end
    end

    // every node on the accessed way's path is flipped to point at the other subtree
    always_comb begin
        w_upd   = r_tree[i_upd_set];
        w_unode = WAY_W'(1);
        for (int l = 0; l < WAY_W; l++) begin
            w_upd[w_unode - 1'b1] = ~i_upd_way[WAY_W-1-l];
            w_unode = (w_unode << 1) | WAY_W'(i_upd_way[WAY_W-1-l]);
        end
    end

    // tree storage: cleared by reset or flush, rewritten for one set per access
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int s = 0; s < NUM_SETS; s++) r_tree[s] <= '0;
        end else if (i_upd_en) begin
            r_tree[i_upd_set] <= w_upd;
        end
    end

endmodule

// File: rtl/icache_assoc_param.sv
// icache_assoc_param: N-way set-associative read-only instruction cache with flush and hit/miss counters
module icache_assoc_param
    import icache_assoc_param_pkg::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int NUM_WAYS   = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        from_cpu_inst_req_valid,
    input  logic [31:0] from_cpu_inst_req_addr,
    output logic        to_cpu_inst_req_ready,
    output logic        to_cpu_cache_rsp_valid,
    output logic [31:0] to_cpu_cache_rsp_data,
    input  logic        from_cpu_cache_rsp_ready,
    input  logic        flush_valid,
    output logic        flush_ready,
    output logic        to_mem_rd_req_valid,
    output logic [31:0] to_mem_rd_req_addr,
    input  logic        from_mem_rd_req_ready,
    input  logic        from_mem_rd_rsp_valid,
    input  logic [31:0] from_mem_rd_rsp_data,
    input  logic        from_mem_rd_rsp_last,
    output logic        to_mem_rd_rsp_ready,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int WAY_W    = $clog2(NUM_WAYS);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_addr;
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [31:0]         r_data  [NUM_SETS][NUM_WAYS][LINE_WORDS];
    logic [31:0]         r_buf   [LINE_WORDS];
    logic [WORD_W-1:0]   r_beat;
    logic [WAY_W-1:0]    r_victim;
    logic [WAY_W-1:0]    r_way;
    logic [31:0]         r_rsp_data;
    logic [31:0]         r_hit_cnt;
    logic [31:0]         r_miss_cnt;

    logic [INDEX_W-1:0]  w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_word;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_any_inv;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_plru_way;
    logic [WAY_W-1:0]    w_victim;
    logic                w_unused;

    assign w_set    = r_addr[OFFSET_W +: INDEX_W];
    assign w_tag    = r_addr[31 -: TAG_W];
    assign w_word   = r_addr[2 +: WORD_W];
    assign w_victim = w_any_inv ? w_inv_way : w_plru_way;
    assign w_unused = ^r_addr[1:0];

    icache_assoc_param_plru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (r_state == S_FLUSH),
        .i_rd_set  (w_set),
        .o_victim  (w_plru_way),
        .i_upd_en  (r_state == S_RESP && from_cpu_cache_rsp_ready),
        .i_upd_set (w_set),
        .i_upd_way (r_way)
    );

    // tag compare in every way; scanning downward leaves the lowest hit and lowest invalid way
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_any_inv = 1'b0;
        w_inv_way = '0;
        for (int k = NUM_WAYS - 1; k >= 0; k--) begin
            if (r_valid[w_set][k] && r_tag[w_set][k] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(k);
            end
            if (!r_valid[w_set][k]) begin
                w_any_inv = 1'b1;
                w_inv_way = WAY_W'(k);
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_next;
    end

    // next state and handshake outputs; a flush request beats a fetch in IDLE
    always_comb begin
        w_next                 = r_state;
        to_cpu_inst_req_ready  = r_state == S_IDLE && !flush_valid;
        flush_ready            = r_state == S_IDLE;
        to_cpu_cache_rsp_valid = r_state == S_RESP;
        to_mem_rd_req_valid    = r_state == S_MEM_REQ;
        to_mem_rd_rsp_ready    = r_state == S_RECV;
        case (r_state)
            S_IDLE:    w_next = flush_valid ? S_FLUSH : from_cpu_inst_req_valid ? S_LOOKUP : S_IDLE;
            S_FLUSH:   w_next = S_IDLE;
            S_LOOKUP:  w_next = w_hit ? S_RESP : S_MEM_REQ;
            S_MEM_REQ: w_next = from_mem_rd_req_ready ? S_RECV : S_MEM_REQ;
            S_RECV:    w_next = (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) ? S_REFILL : S_RECV;
            S_REFILL:  w_next = S_RESP;
            S_RESP:    w_next = from_cpu_cache_rsp_ready ? S_IDLE : S_RESP;
            default:   w_next = S_IDLE;
        endcase
    end

    // fetch address latch, lookup outcome, beat counter, response word and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_beat     <= '0;
            r_victim   <= '0;
            r_way      <= '0;
            r_rsp_data <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && !flush_valid && from_cpu_inst_req_valid) r_addr <= from_cpu_inst_req_addr;
            if (r_state == S_LOOKUP && w_hit) begin
                r_rsp_data <= r_data[w_set][w_hit_way][w_word];
                r_way      <= w_hit_way;
                r_hit_cnt  <= r_hit_cnt + 32'd1;
            end
            if (r_state == S_LOOKUP && !w_hit) begin
                r_victim   <= w_victim;
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
            if (r_state == S_MEM_REQ) r_beat <= '0;
            if (r_state == S_RECV && from_mem_rd_rsp_valid) r_beat <= r_beat + 1'b1;
            if (r_state == S_REFILL) begin
                r_rsp_data <= r_buf[w_word];
                r_way      <= r_victim;
            end
        end
    end

    // line buffer, tag and data storage: payload only, never reset
    always_ff @(posedge clk) begin
        if (r_state == S_RECV && from_mem_rd_rsp_valid) r_buf[r_beat] <= from_mem_rd_rsp_data;
        if (r_state == S_REFILL) begin
            r_tag[w_set][r_victim] <= w_tag;
            for (int k = 0; k < LINE_WORDS; k++) r_data[w_set][r_victim][k] <= r_buf[k];
        end
    end

    // valid bits: cleared by reset or flush, set for the refilled way
    always_ff @(posedge clk) begin
        if (rst || r_state == S_FLUSH) begin
            for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
        end else if (r_state == S_REFILL) begin
            r_valid[w_set][r_victim] <= 1'b1;
        end
    end

    assign to_cpu_cache_rsp_data = r_rsp_data;
    assign to_mem_rd_req_addr    = {r_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign hit_cnt               = r_hit_cnt;
    assign miss_cnt              = r_miss_cnt;

endmodule

// File: tb/tb_icache_assoc_param.sv
// tb_icache_assoc_param: directed fetch, refill, PLRU, flush, back-pressure and reset-abort checks
module tb_icache_assoc_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        from_cpu_inst_req_valid = 1'b0;
    logic [31:0] from_cpu_inst_req_addr = '0;
    logic        to_cpu_inst_req_ready;
    logic        to_cpu_cache_rsp_valid;
    logic [31:0] to_cpu_cache_rsp_data;
    logic        from_cpu_cache_rsp_ready = 1'b0;
    logic        flush_valid = 1'b0;
    logic        flush_ready;
    logic        to_mem_rd_req_valid;
    logic [31:0] to_mem_rd_req_addr;
    logic        from_mem_rd_req_ready = 1'b0;
    logic        from_mem_rd_rsp_valid = 1'b0;
    logic [31:0] from_mem_rd_rsp_data = '0;
    logic        from_mem_rd_rsp_last = 1'b0;
    logic        to_mem_rd_rsp_ready;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          errors = 0;
    int          checks = 0;
    int          g_lat;
    int          g_bursts;
    logic [31:0] g_data;
    logic [31:0] g_maddr;
    logic        g_stable;
    logic        g_done;

    icache_assoc_param dut (
        .clk                      (clk),
        .rst                      (rst),
        .from_cpu_inst_req_valid  (from_cpu_inst_req_valid),
        .from_cpu_inst_req_addr   (from_cpu_inst_req_addr),
        .to_cpu_inst_req_ready    (to_cpu_inst_req_ready),
        .to_cpu_cache_rsp_valid   (to_cpu_cache_rsp_valid),
        .to_cpu_cache_rsp_data    (to_cpu_cache_rsp_data),
        .from_cpu_cache_rsp_ready (from_cpu_cache_rsp_ready),
        .flush_valid              (flush_valid),
        .flush_ready              (flush_ready),
        .to_mem_rd_req_valid      (to_mem_rd_req_valid),
        .to_mem_rd_req_addr       (to_mem_rd_req_addr),
        .from_mem_rd_req_ready    (from_mem_rd_req_ready),
        .from_mem_rd_rsp_valid    (from_mem_rd_rsp_valid),
        .from_mem_rd_rsp_data     (from_mem_rd_rsp_data),
        .from_mem_rd_rsp_last     (from_mem_rd_rsp_last),
        .to_mem_rd_rsp_ready      (to_mem_rd_rsp_ready),
        .hit_cnt                  (hit_cnt),
        .miss_cnt                 (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        return 32'hC0DE_0000 ^ (line + 32'(4 * i));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one fetch at a negedge, act as the burst memory and the CPU until the response is taken
    task automatic fetch(input logic [31:0] a, input int req_hold, input int rsp_hold, input int abort_beats);
        int n;
        int hold;
        int beat;
        bit sending;
        bit seen;
        logic [31:0] line;
        n = 1; hold = req_hold; beat = 0; sending = 0; seen = 0; line = '0;
        g_lat = -1; g_bursts = 0; g_data = '0; g_maddr = '0; g_stable = 1'b1; g_done = 1'b0;
        check("req_ready_idle", to_cpu_inst_req_ready, 1);
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr  = a;
        @(negedge clk);
        from_cpu_inst_req_valid = 1'b0;
        while (!g_done && n < 100) begin
            if (sending) begin
                beat++;
                if (beat == abort_beats) begin
                    rst = 1'b1;
                    from_mem_rd_rsp_valid = 1'b0;
                    from_mem_rd_rsp_last = 1'b0;
                    sending = 0;
                    g_done = 1'b1;
                end else if (beat == 8) begin
                    from_mem_rd_rsp_valid = 1'b0;
                    from_mem_rd_rsp_last = 1'b0;
                    sending = 0;
                end else begin
                    from_mem_rd_rsp_data = mem_word(line, beat);
                    from_mem_rd_rsp_last = (beat == 7);
                end
            end else if (to_mem_rd_req_valid) begin
                if (!seen) begin
                    line = to_mem_rd_req_addr;
                    g_maddr = line;
                    seen = 1;
                end else if (to_mem_rd_req_addr !== line) g_stable = 1'b0;
                if (hold > 0) hold--;
                else begin
                    from_mem_rd_req_ready = 1'b1;
                    g_bursts++;
                end
            end else if (from_mem_rd_req_ready) begin
                from_mem_rd_req_ready = 1'b0;
                sending = 1;
                beat = 0;
                from_mem_rd_rsp_valid = 1'b1;
                from_mem_rd_rsp_data = mem_word(line, 0);
                from_mem_rd_rsp_last = 1'b0;
            end
            if (!g_done && to_cpu_cache_rsp_valid) begin
                if (g_lat < 0) begin
                    g_lat = n;
                    g_data = to_cpu_cache_rsp_data;
                end else if (to_cpu_cache_rsp_data !== g_data) g_stable = 1'b0;
                if (n - g_lat >= rsp_hold) begin
                    from_cpu_cache_rsp_ready = 1'b1;
                    @(negedge clk);
                    from_cpu_cache_rsp_ready = 1'b0;
                    g_done = 1'b1;
                end
            end
            if (!g_done) begin
                @(negedge clk);
                n++;
            end
        end
        check("fetch_done", g_done, 1);
        if (rst) begin
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req_ready", to_cpu_inst_req_ready, 1);
        check("rst_flush_ready", flush_ready, 1);
        check("rst_rsp_valid", to_cpu_cache_rsp_valid, 0);
        check("rst_rsp_data", to_cpu_cache_rsp_data, 0);
        check("rst_mem_req_valid", to_mem_rd_req_valid, 0);
        check("rst_mem_rsp_ready", to_mem_rd_rsp_ready, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        fetch(32'h0000_1004, 0, 0, 0);
        check("cold_data", g_data, 32'hC0DE_1004);
        check("cold_bursts", g_bursts, 1);
        check("cold_mem_addr", g_maddr, 32'h0000_1000);
        check("cold_miss_cnt", miss_cnt, 1);
        check("cold_hit_cnt", hit_cnt, 0);

        fetch(32'h0000_1008, 0, 0, 0);
        check("hit_latency", g_lat, 2);
        check("hit_data", g_data, 32'hC0DE_1008);
        check("hit_bursts", g_bursts, 0);
        check("hit_cnt", hit_cnt, 1);

        flush_valid = 1'b1;
        from_cpu_inst_req_valid = 1'b1;
        from_cpu_inst_req_addr = 32'h0000_1008;
        #1;
        check("flush_wins_req_ready", to_cpu_inst_req_ready, 0);
        check("flush_ready_idle", flush_ready, 1);
        @(negedge clk);
        flush_valid = 1'b0;
        from_cpu_inst_req_valid = 1'b0;
        check("flush_busy", flush_ready, 0);
        @(negedge clk);
        check("flush_no_lookup", hit_cnt, 1);
        fetch(32'h0000_1008, 0, 0, 0);
        check("post_flush_bursts", g_bursts, 1);
        check("post_flush_data", g_data, 32'hC0DE_1008);
        check("post_flush_miss_cnt", miss_cnt, 2);

        fetch(32'h0000_2010, 3, 5, 0);
        check("hold_stable", g_stable, 1);
        check("hold_bursts", g_bursts, 1);
        check("hold_mem_addr", g_maddr, 32'h0000_2000);
        check("hold_data", g_data, 32'hC0DE_2010);
        check("hold_miss_cnt", miss_cnt, 3);

        flush_valid = 1'b1;
        @(negedge clk);
        flush_valid = 1'b0;
        @(negedge clk);

        fetch(32'h0000_0000, 0, 0, 0);
        fetch(32'h0000_0100, 0, 0, 0);
        fetch(32'h0000_0200, 0, 0, 0);
        fetch(32'h0000_0300, 0, 0, 0);
        fetch(32'h0000_0400, 0, 0, 0);
        check("set0_fill_bursts", g_bursts, 1);
        fetch(32'h0000_0000, 0, 0, 0);
        check("plru_evict_bursts", g_bursts, 1);
        check("plru_evict_data", g_data, 32'hC0DE_0000);
        fetch(32'h0000_0104, 0, 0, 0);
        check("plru_keep_bursts", g_bursts, 0);
        check("plru_keep_data", g_data, 32'hC0DE_0104);
        check("set0_miss_cnt", miss_cnt, 9);
        check("set0_hit_cnt", hit_cnt, 2);

        fetch(32'h0000_3000, 0, 0, 4);
        check("abort_req_ready", to_cpu_inst_req_ready, 1);
        check("abort_flush_ready", flush_ready, 1);
        check("abort_mem_req_valid", to_mem_rd_req_valid, 0);
        check("abort_mem_rsp_ready", to_mem_rd_rsp_ready, 0);
        check("abort_hit_cnt", hit_cnt, 0);
        check("abort_miss_cnt", miss_cnt, 0);
        fetch(32'h0000_0104, 0, 0, 0);
        check("abort_refetch_bursts", g_bursts, 1);
        check("abort_refetch_data", g_data, 32'hC0DE_0104);
        check("abort_refetch_miss_cnt", miss_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
